// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl
//   Mode sequencer for the digital clock. Converts debounced key pulses and
//   the alarm-match pulse into the sys_status / tune_status codes, issues
//   one-cycle increment strobes for the time and alarm registers, and
//   enforces the power-up hold, tune-mode idle timeout and alarm ring time.
//
//   Optional feature macro: ALARM_SNOOZE_EN (adds the snooze timer; key_inc
//   while ringing then snoozes instead of dismissing).
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   key_mode     in   one-cycle key pulse (highest priority)
//   key_sel      in   one-cycle key pulse
//   key_inc      in   one-cycle key pulse (lowest priority)
//   alarm_hit    in   one-cycle pulse, current time equals alarm time
//   sys_status   out  [2:0] state code (INIT=0 .. ALARMING=6)
//   tune_status  out  [1:0] selected field (0 none, 3 hour, 2 min, 1 sec)
//   time_inc     out  one-cycle strobe, increment selected time field
//   alarm_inc    out  one-cycle strobe, increment selected alarm field
//   alarm_active out  high while ringing
module clock_mode_ctrl #(
  parameter logic [31:0] INIT_CYCLES   = 32'd50_000_000,
  parameter logic [31:0] IDLE_CYCLES   = 32'd500_000_000,
  parameter logic [31:0] ALARM_CYCLES  = 32'd3_000_000_000,
  parameter logic [31:0] SNOOZE_CYCLES = 32'd2_000_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_sel,
  input  logic       key_inc,
  input  logic       alarm_hit,
  output logic [2:0] sys_status,
  output logic [1:0] tune_status,
  output logic       time_inc,
  output logic       alarm_inc,
  output logic       alarm_active
);

  typedef enum logic [2:0] {
    ST_INIT        = 3'd0,
    ST_NORM        = 3'd1,
    ST_TUNESEL     = 3'd2,
    ST_TUNING      = 3'd3,
    ST_TUNEALARM   = 3'd4,
    ST_ALARMTUNING = 3'd5,
    ST_ALARMING    = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  tune_q, tune_d;
  logic [31:0] cnt_q;
  logic        time_inc_d, alarm_inc_d;

  // Only the highest-priority key of a cycle acts.
  logic k_mode, k_sel, k_inc, any_key;
  assign k_mode  = key_mode;
  assign k_sel   = key_sel & ~key_mode;
  assign k_inc   = key_inc & ~key_mode & ~key_sel;
  assign any_key = key_mode | key_sel | key_inc;

  logic in_tune, idle_to, alarm_to;
  assign in_tune  = (state_q == ST_TUNESEL)   || (state_q == ST_TUNING) ||
                    (state_q == ST_TUNEALARM) || (state_q == ST_ALARMTUNING);
  assign idle_to  = (cnt_q == IDLE_CYCLES - 32'd1);
  assign alarm_to = (cnt_q == ALARM_CYCLES - 32'd1);

  logic snz_due;

`ifdef ALARM_SNOOZE_EN
  logic        snz_armed_q, snz_pend_q;
  logic [31:0] snz_cnt_q;

  // Due as soon as the delay expires; if the FSM is busy elsewhere the
  // request is parked in snz_pend_q until the FSM reaches NORM.
  assign snz_due = snz_pend_q |
                   (snz_armed_q & (snz_cnt_q == SNOOZE_CYCLES - 32'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      snz_armed_q <= 1'b0;
      snz_pend_q  <= 1'b0;
      snz_cnt_q   <= 32'd0;
    end else if (state_q == ST_ALARMING && k_inc) begin
      snz_armed_q <= 1'b1;
      snz_pend_q  <= 1'b0;
      snz_cnt_q   <= 32'd0;
    end else if ((state_q == ST_ALARMING && (any_key || alarm_to)) ||
                 (state_q == ST_NORM && snz_due)) begin
      snz_armed_q <= 1'b0;
      snz_pend_q  <= 1'b0;
    end else if (snz_armed_q) begin
      if (snz_cnt_q == SNOOZE_CYCLES - 32'd1) begin
        snz_armed_q <= 1'b0;
        snz_pend_q  <= 1'b1;
      end else begin
        snz_cnt_q <= snz_cnt_q + 32'd1;
      end
    end
  end
`else
  logic snooze_unused;
  assign snooze_unused = ^SNOOZE_CYCLES;
  assign snz_due       = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    tune_d      = tune_q;
    time_inc_d  = 1'b0;
    alarm_inc_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == INIT_CYCLES - 32'd1) state_d = ST_NORM;
      end
      ST_NORM: begin
        if (snz_due || alarm_hit) begin
          state_d = ST_ALARMING;
        end else if (k_mode) begin
          state_d = ST_TUNESEL;
          tune_d  = 2'd3;
        end else if (k_sel) begin
          state_d = ST_TUNEALARM;
          tune_d  = 2'd3;
        end
      end
      ST_TUNESEL: begin
        if (k_mode) begin
          state_d = ST_NORM;
        end else if (k_sel) begin
          case (tune_q)
            2'd3:    tune_d = 2'd2;
            2'd2:    tune_d = 2'd1;
            default: tune_d = 2'd3;
          endcase
        end else if (k_inc) begin
          state_d = ST_TUNING;
        end else if (idle_to) begin
          state_d = ST_NORM;
        end
      end
      ST_TUNING: begin
        if (k_mode)       state_d    = ST_NORM;
        else if (k_sel)   state_d    = ST_TUNESEL;
        else if (k_inc)   time_inc_d = 1'b1;
        else if (idle_to) state_d    = ST_NORM;
      end
      ST_TUNEALARM: begin
        if (k_mode)       state_d = ST_NORM;
        else if (k_sel)   tune_d  = (tune_q == 2'd3) ? 2'd2 : 2'd3;
        else if (k_inc)   state_d = ST_ALARMTUNING;
        else if (idle_to) state_d = ST_NORM;
      end
      ST_ALARMTUNING: begin
        if (k_mode)       state_d     = ST_NORM;
        else if (k_sel)   state_d     = ST_TUNEALARM;
        else if (k_inc)   alarm_inc_d = 1'b1;
        else if (idle_to) state_d     = ST_NORM;
      end
      ST_ALARMING: begin
        if (any_key || alarm_to) state_d = ST_NORM;
      end
      default: state_d = ST_NORM;
    endcase
    if (state_d == ST_NORM) tune_d = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      tune_q       <= 2'd0;
      cnt_q        <= 32'd0;
      time_inc     <= 1'b0;
      alarm_inc    <= 1'b0;
      alarm_active <= 1'b0;
    end else begin
      state_q      <= state_d;
      tune_q       <= tune_d;
      time_inc     <= time_inc_d;
      alarm_inc    <= alarm_inc_d;
      alarm_active <= (state_d == ST_ALARMING);
      // Shared delay counter: restarts on any state change or acted key.
      if ((state_d != state_q) || (in_tune && any_key)) cnt_q <= 32'd0;
      else if (cnt_q != 32'hFFFF_FFFF)                   cnt_q <= cnt_q + 32'd1;
    end
  end

  assign sys_status  = state_q;
  assign tune_status = tune_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
module tb_clock_mode_ctrl;

  localparam int P_INIT  = 4;
  localparam int P_IDLE  = 20;
  localparam int P_ALARM = 10;
  localparam int P_SNZ   = 8;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNOOZE_ON = 1'b1;
`else
  localparam bit SNOOZE_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_mode = 1'b0, key_sel = 1'b0, key_inc = 1'b0, alarm_hit = 1'b0;
  logic [2:0] sys_status;
  logic [1:0] tune_status;
  logic       time_inc, alarm_inc, alarm_active;

  clock_mode_ctrl #(
    .INIT_CYCLES  (P_INIT),
    .IDLE_CYCLES  (P_IDLE),
    .ALARM_CYCLES (P_ALARM),
    .SNOOZE_CYCLES(P_SNZ)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_mode    (key_mode),
    .key_sel     (key_sel),
    .key_inc     (key_inc),
    .alarm_hit   (alarm_hit),
    .sys_status  (sys_status),
    .tune_status (tune_status),
    .time_inc    (time_inc),
    .alarm_inc   (alarm_inc),
    .alarm_active(alarm_active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: spec rules stepped once per clock, tracking the snooze
  // as an absolute deadline on the model's own step count.
  int      m_st, m_tune, m_n, m_sat;
  bit      m_tinc, m_ainc, m_sarm;
  longint  m_cnt;

  function automatic void model_step(input bit r, m, s, i, h);
    int k, ns, nt;
    bit due, idle;
    m_n++;
    if (r) begin
      m_st = 0; m_tune = 0; m_tinc = 0; m_ainc = 0; m_cnt = 0; m_sarm = 0;
      return;
    end
    k    = m ? 1 : s ? 2 : i ? 3 : 0;
    ns   = m_st;
    nt   = m_tune;
    m_tinc = 0;
    m_ainc = 0;
    due  = SNOOZE_ON && m_sarm && (m_n >= m_sat);
    idle = (k == 0) && (m_cnt == P_IDLE - 1);
    case (m_st)
      0: if (m_cnt == P_INIT - 1) ns = 1;
      1: begin
        if (due || h) begin
          ns = 6;
          if (due) m_sarm = 0;
        end else if (k == 1) begin ns = 2; nt = 3; end
        else if (k == 2) begin ns = 4; nt = 3; end
      end
      2: begin
        if (k == 1) ns = 1;
        else if (k == 2) nt = (m_tune == 1) ? 3 : m_tune - 1;
        else if (k == 3) ns = 3;
        else if (idle) ns = 1;
      end
      3: begin
        if (k == 1) ns = 1;
        else if (k == 2) ns = 2;
        else if (k == 3) m_tinc = 1;
        else if (idle) ns = 1;
      end
      4: begin
        if (k == 1) ns = 1;
        else if (k == 2) nt = 5 - m_tune;
        else if (k == 3) ns = 5;
        else if (idle) ns = 1;
      end
      5: begin
        if (k == 1) ns = 1;
        else if (k == 2) ns = 4;
        else if (k == 3) m_ainc = 1;
        else if (idle) ns = 1;
      end
      6: begin
        if (k != 0) begin
          ns = 1;
          if (SNOOZE_ON && k == 3) begin
            m_sarm = 1;
            m_sat  = m_n + P_SNZ;
          end else begin
            m_sarm = 0;
          end
        end else if (m_cnt == P_ALARM - 1) begin
          ns = 1;
          m_sarm = 0;
        end
      end
      default: ns = 1;
    endcase
    if (ns == 1) nt = 0;
    if (ns != m_st || (m_st >= 2 && m_st <= 5 && k != 0)) m_cnt = 0;
    else if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
    m_st   = ns;
    m_tune = nt;
  endfunction

  task automatic cyc(input bit r, m, s, i, h);
    rst = r; key_mode = m; key_sel = s; key_inc = i; alarm_hit = h;
    @(posedge clk);
    #1;
    model_step(r, m, s, i, h);
    rst = 0; key_mode = 0; key_sel = 0; key_inc = 0; alarm_hit = 0;
  endtask

  task automatic chk_out(input string nm, input int sys, input int tune,
                         input int tinc, input int ainc);
    chk({nm, ".sys"},    sys_status,   sys);
    chk({nm, ".tune"},   tune_status,  tune);
    chk({nm, ".tinc"},   time_inc,     tinc);
    chk({nm, ".ainc"},   alarm_inc,    ainc);
    chk({nm, ".active"}, alarm_active, (sys == 6) ? 1 : 0);
  endtask

  task automatic step_chk(input string nm, input bit m, s, i, h,
                          input int sys, input int tune, input int tinc, input int ainc);
    cyc(1'b0, m, s, i, h);
    chk_out(nm, sys, tune, tinc, ainc);
  endtask

  task automatic idle_chk(input string nm, input int n, input int sys, input int tune);
    for (int j = 0; j < n; j++) step_chk($sformatf("%s[%0d]", nm, j), 0, 0, 0, 0, sys, tune, 0, 0);
  endtask

  typedef struct {
    bit m, s, i, h;
    int sys, tune, tinc, ainc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit m, s, i, h, input int sys, tune, tinc, ainc);
    vec_t v;
    v.m = m; v.s = s; v.i = i; v.h = h;
    v.sys = sys; v.tune = tune; v.tinc = tinc; v.ainc = ainc;
    return v;
  endfunction

  initial begin
    // INIT hold with keys ignored, then tune-time and tune-alarm walks
    tbl.push_back(mk(1,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,1,1, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,0,0,0));
    tbl.push_back(mk(1,0,0,0, 2,3,0,0));
    tbl.push_back(mk(0,1,0,0, 2,2,0,0));
    tbl.push_back(mk(0,1,0,0, 2,1,0,0));
    tbl.push_back(mk(0,1,0,0, 2,3,0,0));
    tbl.push_back(mk(0,0,1,0, 3,3,0,0));
    tbl.push_back(mk(0,0,1,0, 3,3,1,0));
    tbl.push_back(mk(0,0,0,0, 3,3,0,0));
    tbl.push_back(mk(0,0,1,0, 3,3,1,0));
    tbl.push_back(mk(0,0,1,0, 3,3,1,0));
    tbl.push_back(mk(0,0,0,0, 3,3,0,0));
    tbl.push_back(mk(1,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0,1,0,0, 4,3,0,0));
    tbl.push_back(mk(0,1,0,0, 4,2,0,0));
    tbl.push_back(mk(0,1,0,0, 4,3,0,0));
    tbl.push_back(mk(0,1,0,0, 4,2,0,0));
    tbl.push_back(mk(0,0,1,0, 5,2,0,0));
    tbl.push_back(mk(0,0,1,0, 5,2,0,1));
    tbl.push_back(mk(0,0,0,0, 5,2,0,0));
    tbl.push_back(mk(0,0,0,1, 5,2,0,0));
    tbl.push_back(mk(0,1,0,0, 4,2,0,0));
    tbl.push_back(mk(1,0,0,0, 1,0,0,0));
    tbl.push_back(mk(1,0,0,1, 6,0,0,0));

    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 1);
    chk_out("reset", 0, 0, 0, 0);

    for (int v = 0; v < tbl.size(); v++)
      step_chk($sformatf("vec%0d", v), tbl[v].m, tbl[v].s, tbl[v].i, tbl[v].h,
               tbl[v].sys, tbl[v].tune, tbl[v].tinc, tbl[v].ainc);

    // ring timeout: 10 cycles of ALARMING in total, then NORM
    idle_chk("ring", P_ALARM - 1, 6, 0);
    idle_chk("ring_end", 1, 1, 0);

    // key_inc while ringing
    step_chk("hit2", 0, 0, 0, 1, 6, 0, 0, 0);
    step_chk("inc_ring", 0, 0, 1, 0, 1, 0, 0, 0);
    if (SNOOZE_ON) begin
      idle_chk("snz_wait", P_SNZ - 1, 1, 0);
      idle_chk("snz_ring", 1, 6, 0);
      step_chk("snz_dismiss", 1, 0, 0, 0, 1, 0, 0, 0);
    end
    idle_chk("norm_quiet", 12, 1, 0);

    // idle timeout in TUNESEL
    step_chk("to_mode", 1, 0, 0, 0, 2, 3, 0, 0);
    idle_chk("to_wait", P_IDLE - 1, 2, 3);
    idle_chk("to_fire", 1, 1, 0);

    // key on the timeout cycle restarts the count
    step_chk("tk_mode", 1, 0, 0, 0, 2, 3, 0, 0);
    idle_chk("tk_wait", P_IDLE - 1, 2, 3);
    step_chk("tk_sel", 0, 1, 0, 0, 2, 2, 0, 0);
    idle_chk("tk_wait2", P_IDLE - 1, 2, 2);
    idle_chk("tk_fire", 1, 1, 0);

    // alarm_hit in TUNING dropped; simultaneous keys resolve to key_mode
    step_chk("tn_mode", 1, 0, 0, 0, 2, 3, 0, 0);
    step_chk("tn_inc", 0, 0, 1, 0, 3, 3, 0, 0);
    step_chk("tn_hit", 0, 0, 0, 1, 3, 3, 0, 0);
    step_chk("tn_all", 1, 1, 1, 0, 1, 0, 0, 0);
    idle_chk("tn_after", 3, 1, 0);

    // key_sel dismisses the ring
    step_chk("hit3", 0, 0, 0, 1, 6, 0, 0, 0);
    step_chk("sel_ring", 0, 1, 0, 0, 1, 0, 0, 0);

    // randomized run against the reference model
    cyc(1, 0, 0, 0, 0);
    for (int c = 0; c < 4000; c++) begin
      int thr;
      bit r, m, s, i, h;
      thr = ((c / 64) % 2 == 0) ? 5 : 40;
      r = ($urandom_range(0, 799) == 0);
      m = ($urandom_range(0, thr - 1) == 0);
      s = ($urandom_range(0, thr - 1) == 0);
      i = ($urandom_range(0, thr - 1) == 0);
      h = ($urandom_range(0, thr) == 0);
      cyc(r, m, s, i, h);
      chk_out($sformatf("rnd%0d", c), m_st, m_tune, m_tinc, m_ainc);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
